// File: rtl/core_pkg.sv
// Shared types and constants for the core pipeline control logic.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MDU_WAIT = 2'd2
  } hz_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_m;
    logic flush_w;
  } hz_ctl_t;

  localparam hz_ctl_t CTL_NONE = 8'b0000_0000;
  localparam hz_ctl_t CTL_BOOT = 8'b0000_1111;
  localparam hz_ctl_t CTL_MEMW = 8'b1111_0001;
  localparam hz_ctl_t CTL_BR   = 8'b0000_1100;
  localparam hz_ctl_t CTL_MDU  = 8'b1110_0010;
  localparam hz_ctl_t CTL_LU   = 8'b1100_0100;

  function automatic logic ctl_any_stall(input hz_ctl_t c);
    return c.stall_f | c.stall_d | c.stall_e | c.stall_m;
  endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forwarding select for one E-stage source operand; M result wins over W.
module hazard_fwd_unit
  import core_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              en,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic              reg_write_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [1:0]        fwd_sel
);

  logic hit_m;
  logic hit_w;

  // x0 is hardwired zero, so it can never be a forwarding source.
  assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == rs_e);
  assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == rs_e);

  always_comb begin
    fwd_sel = FWD_RF;
    if (en) begin
      if (hit_m)      fwd_sel = FWD_M;
      else if (hit_w) fwd_sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control: boot flush, load-use, branch redirect,
// multi-cycle MDU sequencing, memory wait states and E-stage forwarding.
module hazard_ctrl
  import core_pkg::*;
#(
  parameter int BOOT_FLUSH = 4,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rs1_e,
  input  logic [REG_AW-1:0] rs2_e,
  input  logic [REG_AW-1:0] rd_e,
  input  logic              mem_read_e,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_m,
  input  logic              reg_write_w,
  input  logic              branch_taken_e,
  input  logic              mdu_start_e,
  input  logic              mdu_done,
  input  logic              mem_wait,
  output logic              stall_f,
  output logic              stall_d,
  output logic              stall_e,
  output logic              stall_m,
  output logic              flush_d,
  output logic              flush_e,
  output logic              flush_m,
  output logic              flush_w,
  output logic [1:0]        fwd_a_e,
  output logic [1:0]        fwd_b_e,
  output logic [CNT_W-1:0]  stall_cnt,
  output hz_state_t         dbg_state
);

  localparam int BCW = (BOOT_FLUSH > 1) ? $clog2(BOOT_FLUSH) : 1;
  localparam logic [BCW-1:0] BOOT_INIT = BCW'(BOOT_FLUSH - 1);

  hz_state_t       state_q, state_d;
  logic [BCW-1:0]  boot_q, boot_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hz_ctl_t         ctl;
  logic            load_use;

  assign load_use = mem_read_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

  always_comb begin
    ctl     = CTL_NONE;
    state_d = state_q;
    boot_d  = boot_q;
    case (state_q)
      BOOT: begin
        ctl = CTL_BOOT;
        if (boot_q == '0) state_d = RUN;
        else              boot_d  = boot_q - BCW'(1);
      end
      RUN: begin
        if (mem_wait)            ctl = CTL_MEMW;
        else if (branch_taken_e) ctl = CTL_BR;
        else if (mdu_start_e && !mdu_done) begin
          ctl     = CTL_MDU;
          state_d = MDU_WAIT;
        end
        else if (load_use)       ctl = CTL_LU;
      end
      MDU_WAIT: begin
        // The done cycle releases the stall so E advances with the result.
        if (mem_wait)       ctl = CTL_MEMW;
        else if (!mdu_done) ctl = CTL_MDU;
        if (mdu_done) state_d = RUN;
      end
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (ctl_any_stall(ctl) && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BOOT;
      boot_q  <= BOOT_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      boot_q  <= boot_d;
      cnt_q   <= cnt_d;
    end
  end

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .en          (state_q != BOOT),
    .rs_e        (rs1_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_a_e)
  );

  hazard_fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .en          (state_q != BOOT),
    .rs_e        (rs2_e),
    .rd_m        (rd_m),
    .reg_write_m (reg_write_m),
    .rd_w        (rd_w),
    .reg_write_w (reg_write_w),
    .fwd_sel     (fwd_b_e)
  );

  assign stall_f   = ctl.stall_f;
  assign stall_d   = ctl.stall_d;
  assign stall_e   = ctl.stall_e;
  assign stall_m   = ctl.stall_m;
  assign flush_d   = ctl.flush_d;
  assign flush_e   = ctl.flush_e;
  assign flush_m   = ctl.flush_m;
  assign flush_w   = ctl.flush_w;
  assign stall_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with a 4-bit stall counter to reach saturation.
module tb_hazard_ctrl;
  import core_pkg::*;

  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic              mem_read_e, reg_write_m, reg_write_w;
  logic              branch_taken_e, mdu_start_e, mdu_done, mem_wait;
  logic              stall_f, stall_d, stall_e, stall_m;
  logic              flush_d, flush_e, flush_m, flush_w;
  logic [1:0]        fwd_a_e, fwd_b_e;
  logic [CNT_W-1:0]  stall_cnt;
  hz_state_t         dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  hazard_ctrl #(.BOOT_FLUSH(4), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .mem_read_e(mem_read_e),
    .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .branch_taken_e(branch_taken_e), .mdu_start_e(mdu_start_e),
    .mdu_done(mdu_done), .mem_wait(mem_wait),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_cnt(stall_cnt), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic clr();
    rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0;
    mem_read_e = 1'b0; reg_write_m = 1'b0; reg_write_w = 1'b0;
    branch_taken_e = 1'b0; mdu_start_e = 1'b0; mdu_done = 1'b0; mem_wait = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Checkers; a stalled cycle is expected to bump the counter at the next edge
  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, obs, exp);
    end
    if (|exp[7:4] && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic chk_fwd(input string tag, input logic [1:0] exp_a, input logic [1:0] exp_b);
    checks++;
    assert ({fwd_a_e, fwd_b_e} === {exp_a, exp_b}) else begin
      failures++;
      $error("FAIL %s fwd observed=%b/%b expected=%b/%b", tag, fwd_a_e, fwd_b_e, exp_a, exp_b);
    end
  endtask

  task automatic chk_cnt(input string tag);
    checks++;
    assert (stall_cnt === exp_cnt) else begin
      failures++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_cnt);
    end
  endtask

  task automatic chk_state(input string tag, input hz_state_t exp);
    checks++;
    assert (dbg_state === exp) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, dbg_state, exp);
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    // Hazard and forwarding inputs must be ignored throughout boot
    mem_wait = 1'b1; branch_taken_e = 1'b1; mdu_start_e = 1'b1;
    mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    reg_write_m = 1'b1; rd_m = 5'd7; rs1_e = 5'd7; rs2_e = 5'd7;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      chk_ctl("boot_flush", 8'b0000_1111);
      chk_fwd("boot_fwd", FWD_RF, FWD_RF);
      if (i == 0) begin
        chk_state("boot_state", BOOT);
        chk_cnt("cnt_reset");
      end
    end
    cyc(); clr(); #1;
    chk_state("run_after_boot", RUN);
    chk_ctl("run_idle", 8'b0000_0000);
    chk_cnt("cnt_after_boot");

    // Load-use
    cyc(); mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; #1;
    chk_ctl("lu_rs1", 8'b1100_0100);
    cyc(); clr(); #1;
    chk_ctl("lu_bubble", 8'b0000_0000);
    chk_cnt("cnt_lu");
    cyc(); mem_read_e = 1'b1; rd_e = 5'd0; #1;
    chk_ctl("lu_x0", 8'b0000_0000);
    cyc(); clr(); mem_read_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd4; rs2_d = 5'd9; #1;
    chk_ctl("lu_rs2", 8'b1100_0100);
    cyc(); clr(); rd_e = 5'd9; rs1_d = 5'd9; #1;
    chk_ctl("no_load", 8'b0000_0000);

    // Branch beats load-use; mem_wait beats branch
    cyc(); clr(); branch_taken_e = 1'b1; mem_read_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5; #1;
    chk_ctl("br_lu", 8'b0000_1100);
    cyc(); mem_wait = 1'b1; #1;
    chk_ctl("memw_br", 8'b1111_0001);

    // MDU start is deferred by mem_wait or branch
    cyc(); clr(); mem_wait = 1'b1; mdu_start_e = 1'b1; #1;
    chk_ctl("memw_mdu", 8'b1111_0001);
    cyc(); clr(); #1;
    chk_state("no_mdu_entry_memw", RUN);
    cyc(); branch_taken_e = 1'b1; mdu_start_e = 1'b1; #1;
    chk_ctl("br_mdu", 8'b0000_1100);
    cyc(); clr(); #1;
    chk_state("no_mdu_entry_br", RUN);
    chk_cnt("cnt_mid");

    // MDU op: done arrives 6 cycles after start, mem_wait in cycle 3
    cyc(); mdu_start_e = 1'b1; #1;
    chk_ctl("mdu_c0", 8'b1110_0010);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      mem_wait = (c == 3);
      mdu_done = (c == 6);
      #1;
      chk_state("mdu_wait_state", MDU_WAIT);
      if (c == 6)      chk_ctl("mdu_done", 8'b0000_0000);
      else if (c == 3) chk_ctl("mdu_memw", 8'b1111_0001);
      else             chk_ctl("mdu_wait", 8'b1110_0010);
    end
    cyc(); clr(); #1;
    chk_state("mdu_back_run", RUN);
    chk_ctl("mdu_after", 8'b0000_0000);
    chk_cnt("cnt_mdu");

    // Forwarding
    cyc(); reg_write_m = 1'b1; reg_write_w = 1'b1; rd_m = 5'd7; rd_w = 5'd7; rs1_e = 5'd7; #1;
    chk_fwd("fwd_m_prio", FWD_M, FWD_RF);
    cyc(); reg_write_m = 1'b0; #1;
    chk_fwd("fwd_w", FWD_W, FWD_RF);
    cyc(); rd_w = 5'd0; rs1_e = 5'd0; rs2_e = 5'd0; #1;
    chk_fwd("fwd_x0", FWD_RF, FWD_RF);
    cyc(); clr(); reg_write_m = 1'b1; reg_write_w = 1'b1;
    rd_m = 5'd7; rs1_e = 5'd7; rd_w = 5'd3; rs2_e = 5'd3; #1;
    chk_fwd("fwd_mixed", FWD_M, FWD_W);
    cyc(); rd_m = 5'd3; #1;
    chk_fwd("fwd_b_m", FWD_RF, FWD_M);

    // Stall counter saturation
    for (int i = 0; i < 20; i++) begin
      cyc(); clr(); mem_wait = 1'b1; #1;
      chk_ctl("sat_memw", 8'b1111_0001);
    end
    cyc(); clr(); #1;
    chk_cnt("cnt_sat");
    cyc(); mem_wait = 1'b1; #1;
    chk_ctl("sat_more", 8'b1111_0001);
    cyc(); clr(); #1;
    chk_cnt("cnt_hold");

    // Reset in the middle of an MDU wait
    cyc(); mdu_start_e = 1'b1; #1;
    chk_ctl("rst_mdu_c0", 8'b1110_0010);
    cyc(); #1;
    chk_state("rst_mdu_wait", MDU_WAIT);
    rst = 1'b1; mem_wait = 1'b1;
    cyc();
    rst = 1'b0; clr(); mdu_start_e = 1'b1; exp_cnt = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      #1;
      chk_ctl("reboot_flush", 8'b0000_1111);
      if (i == 0) begin
        chk_state("reboot_state", BOOT);
        chk_cnt("reboot_cnt");
      end
    end
    cyc(); clr(); #1;
    chk_state("reboot_run", RUN);
    chk_ctl("reboot_idle", 8'b0000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
